// File: rtl/cp0_exc_unit.sv
// MIPS-style CP0 exception/interrupt unit: SR, Cause, EPC, PRId and handler-entry request.
// Optional Count/Compare timer is built when CP0_EXC_UNIT_TIMER_EN is defined.
module cp0_exc_unit #(
    parameter int unsigned HW_IRQ_NUM = 6,
    parameter logic [31:0] PRID_VALUE = 32'h0000_0001
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  En,
    input  logic [4:0]            CP0Add,
    input  logic [31:0]           CP0In,
    output logic [31:0]           CP0Out,
    input  logic [31:0]           VPC,
    input  logic                  BDIn,
    input  logic [4:0]            ExcCodeIn,
    input  logic [HW_IRQ_NUM-1:0] HWInt,
    input  logic                  EXLClr,
    output logic [31:0]           EPCOut,
    output logic                  Req
);

    localparam logic [4:0] AddrCount   = 5'd9;
    localparam logic [4:0] AddrCompare = 5'd11;
    localparam logic [4:0] AddrSr      = 5'd12;
    localparam logic [4:0] AddrCause   = 5'd13;
    localparam logic [4:0] AddrEpc     = 5'd14;
    localparam logic [4:0] AddrPrid    = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  hw_pad;
    logic [5:0]  pend;
    logic [5:0]  ip_rd;
    logic        int_req, exc_req, req;
    logic [31:0] epc_victim;

    // Missing interrupt lines read as 0.
    always_comb begin
        hw_pad = '0;
        hw_pad[HW_IRQ_NUM-1:0] = HWInt;
    end

`ifdef CP0_EXC_UNIT_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    assign pend  = {hw_pad[5] | ti_q, hw_pad[4:0]};
    assign ip_rd = {ip_q[5] | ti_q, ip_q[4:0]};

    // Writes are dropped while entering the handler, so the increment still happens then.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (En && !req && CP0Add == AddrCount) begin
            count_d = CP0In;
        end
        if (En && !req && CP0Add == AddrCompare) begin
            compare_d = CP0In;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end
`else
    assign pend  = hw_pad;
    assign ip_rd = ip_q;
`endif

    assign int_req    = (|(pend & im_q)) & ie_q & ~exl_q;
    assign exc_req    = (ExcCodeIn != 5'd0) & ~exl_q;
    assign req        = (int_req | exc_req) & ~Reset;
    assign Req        = req;
    assign epc_victim = BDIn ? (VPC - 32'd4) : VPC;
    assign EPCOut     = epc_q;

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = hw_pad;
        exc_d = exc_q;
        epc_d = epc_q;
        if (req) begin
            exl_d = 1'b1;
            bd_d  = BDIn;
            epc_d = {epc_victim[31:2], 2'b00};
            exc_d = int_req ? 5'd0 : ExcCodeIn;
        end else begin
            if (EXLClr) begin
                exl_d = 1'b0;
            end
            if (En && CP0Add == AddrSr) begin
                im_d = CP0In[15:10];
                ie_d = CP0In[0];
                // eret wins over a simultaneous mtc0 to EXL.
                if (!EXLClr) begin
                    exl_d = CP0In[1];
                end
            end
            if (En && CP0Add == AddrEpc) begin
                epc_d = {CP0In[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        CP0Out = 32'h0;
        case (CP0Add)
            AddrSr:    CP0Out = {16'h0, im_q, 8'h0, exl_q, ie_q};
            AddrCause: CP0Out = {bd_q, 15'h0, ip_rd, 3'b000, exc_q, 2'b00};
            AddrEpc:   CP0Out = epc_q;
            AddrPrid:  CP0Out = PRID_VALUE;
`ifdef CP0_EXC_UNIT_TIMER_EN
            AddrCount:   CP0Out = count_q;
            AddrCompare: CP0Out = compare_q;
`endif
            default:   CP0Out = 32'h0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^{CP0In[31:16], CP0In[9:2], CP0In[1:0]};

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: vector table plus reset, collision and timer sequences.
module tb_cp0_exc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        En;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_exc_unit dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .CP0Add   (CP0Add),
        .CP0In    (CP0In),
        .CP0Out   (CP0Out),
        .VPC      (VPC),
        .BDIn     (BDIn),
        .ExcCodeIn(ExcCodeIn),
        .HWInt    (HWInt),
        .EXLClr   (EXLClr),
        .EPCOut   (EPCOut),
        .Req      (Req)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic en, input logic [4:0] addr, input logic [31:0] din,
                                input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                                input logic [5:0] hw, input logic clr, input logic req,
                                input logic [31:0] dout, input logic [31:0] epc);
        vec_t v;
        v.en = en; v.addr = addr; v.din = din; v.vpc = vpc; v.bd = bd; v.exc = exc;
        v.hw = hw; v.clr = clr; v.req = req; v.dout = dout; v.epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        En = 1'b0; CP0Add = 5'd0; CP0In = '0; VPC = '0; BDIn = 1'b0;
        ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic write(input logic [4:0] addr, input logic [31:0] data);
        idle();
        En = 1'b1; CP0Add = addr; CP0In = data;
        cycle();
        idle();
    endtask

    initial begin
        // en addr din vpc bd exc hw clr | req dout epc
        vecs[0]  = mk(0, 12, 0, 0, 0, 0, 0, 0,                  0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 15, 0, 0, 0, 0, 0, 0,                  0, 32'h1, 32'h0);
        vecs[2]  = mk(0, 13, 0, 32'h3008, 0, 12, 0, 0,          1, 32'h0, 32'h0);
        vecs[3]  = mk(0, 13, 0, 0, 0, 0, 0, 0,                  0, 32'h30, 32'h3008);
        vecs[4]  = mk(0, 12, 0, 32'h7000, 0, 12, 0, 0,          0, 32'h2, 32'h3008);
        vecs[5]  = mk(0, 12, 0, 0, 0, 0, 0, 1,                  0, 32'h2, 32'h3008);
        vecs[6]  = mk(0, 12, 0, 32'h3010, 1, 4, 0, 0,           1, 32'h0, 32'h3008);
        vecs[7]  = mk(0, 13, 0, 0, 0, 0, 0, 0,                  0, 32'h8000_0010, 32'h300C);
        vecs[8]  = mk(0, 14, 0, 0, 0, 0, 0, 1,                  0, 32'h300C, 32'h300C);
        vecs[9]  = mk(1, 12, 32'h401, 0, 0, 0, 1, 0,            0, 32'h0, 32'h300C);
        vecs[10] = mk(0, 13, 0, 32'h4000, 0, 10, 1, 0,          1, 32'h8000_0410, 32'h300C);
        vecs[11] = mk(0, 13, 0, 0, 0, 0, 0, 0,                  0, 32'h400, 32'h4000);
        vecs[12] = mk(1, 12, 32'h400, 0, 0, 0, 0, 1,            0, 32'h403, 32'h4000);
        vecs[13] = mk(0, 12, 0, 0, 0, 0, 1, 0,                  0, 32'h400, 32'h4000);
        vecs[14] = mk(1, 12, 32'h401, 0, 0, 0, 0, 0,            0, 32'h400, 32'h4000);
        vecs[15] = mk(1, 14, 32'hFFFF_FFFF, 32'h5000, 0, 8, 0, 0, 1, 32'h4000, 32'h4000);
        vecs[16] = mk(0, 14, 0, 0, 0, 0, 0, 0,                  0, 32'h5000, 32'h5000);
        vecs[17] = mk(1, 12, 32'h403, 0, 0, 0, 0, 1,            0, 32'h403, 32'h5000);
        vecs[18] = mk(0, 12, 0, 0, 0, 0, 0, 0,                  0, 32'h401, 32'h5000);
        vecs[19] = mk(1, 14, 32'h1234_5677, 0, 0, 0, 0, 0,      0, 32'h5000, 32'h5000);
        vecs[20] = mk(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,      0, 32'h20, 32'h1234_5674);
        vecs[21] = mk(1, 12, 32'h0000_7C03, 0, 0, 0, 0, 0,      0, 32'h401, 32'h1234_5674);
        vecs[22] = mk(0, 13, 0, 0, 0, 0, 0, 0,                  0, 32'h20, 32'h1234_5674);
        vecs[23] = mk(0, 12, 0, 0, 0, 0, 0, 0,                  0, 32'h7C03, 32'h1234_5674);
        vecs[24] = mk(0, 10, 0, 0, 0, 0, 0, 1,                  0, 32'h0, 32'h1234_5674);
        vecs[25] = mk(0, 0, 0, 32'h0, 1, 2, 0, 0,               1, 32'h0, 32'h1234_5674);
        vecs[26] = mk(0, 14, 0, 0, 0, 0, 0, 0,                  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        vecs[27] = mk(0, 13, 0, 0, 0, 0, 0, 0,                  0, 32'h8000_0008, 32'hFFFF_FFFC);

        // Reset state, with a pending exception input that must not raise Req.
        idle();
        Reset = 1'b1;
        ExcCodeIn = 5'd7;
        CP0Add = 5'd12;
        #12;
        check("reset_req", {31'h0, Req}, 32'h0);
        check("reset_epc", EPCOut, 32'h0);
        check("reset_sr", CP0Out, 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        idle();

`ifdef CP0_EXC_UNIT_TIMER_EN
        write(5'd11, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 28; i++) begin
            En = vecs[i].en; CP0Add = vecs[i].addr; CP0In = vecs[i].din;
            VPC = vecs[i].vpc; BDIn = vecs[i].bd; ExcCodeIn = vecs[i].exc;
            HWInt = vecs[i].hw; EXLClr = vecs[i].clr;
            #3;
            check($sformatf("vec%0d_req", i), {31'h0, Req}, {31'h0, vecs[i].req});
            check($sformatf("vec%0d_dout", i), CP0Out, vecs[i].dout);
            check($sformatf("vec%0d_epc", i), EPCOut, vecs[i].epc);
            cycle();
        end
        idle();

        // Async reset mid-cycle while EXL=1.
        CP0Add = 5'd12;
        #1;
        check("pre_async_sr", CP0Out, 32'h7C03);
        #1;
        Reset = 1'b1;
        #1;
        check("async_sr", CP0Out, 32'h0);
        CP0Add = 5'd13;
        #1;
        check("async_cause", CP0Out, 32'h0);
        check("async_epc", EPCOut, 32'h0);
        check("async_req", {31'h0, Req}, 32'h0);

        // Reset asserted in the same cycle as a Req must leave nothing behind.
        cycle();
        Reset = 1'b0;
        ExcCodeIn = 5'd3; VPC = 32'h6000; BDIn = 1'b1;
        #1;
        check("pre_rst_req", {31'h0, Req}, 32'h1);
        #1;
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        idle();
        CP0Add = 5'd14;
        #1;
        check("rst_dom_epc", CP0Out, 32'h0);
        CP0Add = 5'd13;
        #1;
        check("rst_dom_cause", CP0Out, 32'h0);
        CP0Add = 5'd12;
        #1;
        check("rst_dom_sr", CP0Out, 32'h0);
        cycle();

`ifdef CP0_EXC_UNIT_TIMER_EN
        write(5'd11, 32'd5);
        write(5'd9, 32'd0);
        CP0Add = 5'd9;
        #1;
        check("count_written", CP0Out, 32'h0);
        idle();
        write(5'd12, 32'h0000_8001);
        begin
            int waited;
            waited = 0;
            while (!Req && waited < 20) begin
                cycle();
                waited++;
            end
            check("timer_req", {31'h0, Req}, 32'h1);
        end
        CP0Add = 5'd13;
        #1;
        check("timer_ip15", CP0Out & 32'h8000, 32'h8000);
        cycle();
        CP0Add = 5'd13;
        #1;
        check("timer_exccode", CP0Out & 32'h7C, 32'h0);
        write(5'd11, 32'd100);
        CP0Add = 5'd13;
        #1;
        check("timer_ip15_clr", CP0Out & 32'h8000, 32'h0);
        CP0Add = 5'd11;
        #1;
        check("compare_rd", CP0Out, 32'd100);
        idle();
`else
        write(5'd9, 32'h55);
        CP0Add = 5'd9;
        #1;
        check("count_absent", CP0Out, 32'h0);
        idle();
        write(5'd11, 32'h66);
        CP0Add = 5'd11;
        #1;
        check("compare_absent", CP0Out, 32'h0);
        idle();
`endif

        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 SHALL have parameter HW_IRQ_NUM, default 6, number of external interrupt lines (legal 1..6).
REQ-002 SHALL have parameter PRID_VALUE, default 32'h0000_0001, read-only value of PRId (addr 15).
REQ-003 SHALL have port Clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports En in 1 (mtc0 write enable); CP0Add in 5 (register address); CP0In in 32 (write data); CP0Out out 32 (read data, combinational).
REQ-006 SHALL have ports VPC in 32 (victim PC); BDIn in 1 (victim is in a delay slot); ExcCodeIn in 5 (nonzero = synchronous exception); HWInt in HW_IRQ_NUM (level interrupt lines); EXLClr in 1 (eret).
REQ-007 SHALL have ports EPCOut out 32 (current EPC); Req out 1 (enter handler this cycle, combinational).

Function
REQ-008 SR (addr 12) SHALL implement only IM[15:10], EXL[1] and IE[0]; all other bits SHALL read 0 and ignore writes.
REQ-009 Cause (addr 13) SHALL implement BD[31], IP[15:10] and ExcCode[6:2]; all other bits SHALL read 0; Cause SHALL be read-only to mtc0.
REQ-010 IP[10+i] SHALL be registered from HWInt[i] every cycle; IP bits at or above HW_IRQ_NUM SHALL read 0 unless REQ-022 applies.
REQ-011 EPC (addr 14) SHALL be writable by mtc0 with bits [1:0] forced to 0; EPCOut SHALL equal EPC.
REQ-012 Reads of any unimplemented address SHALL return 32'h0; addr 15 SHALL return PRID_VALUE.
REQ-013 IntReq SHALL equal |(Pend & IM) & IE & ~EXL, where Pend is the combinational value of HWInt (plus TI, per REQ-022) in the current cycle.
REQ-014 ExcReq SHALL equal (ExcCodeIn != 0) & ~EXL; Req SHALL equal IntReq | ExcReq.
REQ-015 On a clock edge with Req=1: EXL<=1; BD<=BDIn; EPC<=(BDIn ? VPC-4 : VPC) with [1:0] forced to 0; ExcCode<=0 when IntReq=1, otherwise ExcCodeIn. Interrupts SHALL take priority over exceptions.
REQ-016 With Req=1 and En=1 in the same cycle, the mtc0 write SHALL be dropped entirely.
REQ-017 EXLClr=1 SHALL clear EXL at the next edge; if EXLClr and an mtc0 write to SR coincide, EXL SHALL be 0 and IM/IE SHALL take CP0In.
REQ-018 While EXL=1, Req SHALL be 0 and EPC, BD and ExcCode SHALL hold (except EPC via mtc0).
REQ-019 VPC-4 SHALL wrap modulo 2^32.

Reset
REQ-020 Reset SHALL clear SR, Cause, EPC (and Count, Compare, TI when enabled) to 0 asynchronously; EPCOut=0 and Req=0 during reset.
REQ-021 A Reset asserted in the same cycle as Req SHALL dominate; no state from the Req SHALL survive.

Configuration
REQ-022 With macro CP0_EXC_UNIT_TIMER_EN defined: Count (addr 9) SHALL increment every cycle and wrap at 2^32; Compare (addr 11) SHALL be writable; TI SHALL set when Count==Compare and clear on any Compare write; IP[15] SHALL read HWInt[5] | TI, with HWInt[5] treated as 0 when HW_IRQ_NUM<6; an mtc0 write to Count SHALL override that cycle's increment.
REQ-023 Without CP0_EXC_UNIT_TIMER_EN: addrs 9 and 11 SHALL read 0 and ignore writes; no timer logic SHALL be present.

Verification
REQ-024 Exception: SR=0, ExcCodeIn=5'd12, VPC=32'h0000_3008, BDIn=0 -> Req=1; next cycle EPC=32'h0000_3008, Cause[6:2]=12, SR[1]=1, Req=0.
REQ-025 Delay slot: ExcCodeIn=5'd4, VPC=32'h0000_3010, BDIn=1 -> EPC=32'h0000_300C, Cause[31]=1.
REQ-026 Interrupt priority: SR=32'h0000_0401, HWInt[0]=1, ExcCodeIn=5'd10 in the same cycle -> Req=1, ExcCode=0, IP[10]=1; with IE=0 -> Req=0.
REQ-027 Collision: Req=1 and mtc0 to EPC of 32'hFFFF_FFFF in the same cycle -> EPC=VPC; then EXLClr together with mtc0 SR=32'h0000_0403 -> SR reads 32'h0000_0401.
REQ-028 Timer (macro on): Compare=5, Count=0, SR=32'h0000_8001 -> TI sets when Count==5, Req=1, ExcCode=0; writing Compare clears IP[15].
REQ-029 Async reset: Reset asserted mid-cycle while EXL=1 -> SR, Cause and EPC read 0 before the next Clk edge.
